mdu_controller: RTL and testbench

//   Sequences the multi-cycle multiply/divide unit and owns the HI/LO register pair.

---
 rtl/mdu_controller_pkg.sv | 41 ++++
 rtl/mdu_arith.sv | 68 ++++++
 rtl/mdu_controller.sv | 128 ++++++++++++
 tb/tb_mdu_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_controller_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e    : E-stage MDU op encodings (6-7 reserved, treated as no-op)
//   mdu_state_e : controller FSM states
//   mdu_res_t   : arithmetic result bundle {hi, lo, div0}
package mdu_controller_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_RSV6  = 3'd6,
    MDU_RSV7  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div0;
  } mdu_res_t;

  // Multi-cycle ops (mult/multu/div/divu) occupy encodings 0-3.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Div/divu are encodings 2-3; they use the divide latency.
  function automatic logic is_div_op(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
//   op_i  : MDU op (only 0-3 produce a result)
//   a_i   : operand A (multiplicand / dividend)
//   b_i   : operand B (multiplier / divisor)
//   res_o : {hi, lo, div0}; div0 flags a zero divisor for div/divu
module mdu_arith
  import mdu_controller_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output mdu_res_t        res_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN-1:0]   sdiv_b;
  logic [XLEN-1:0]   udiv_b;
  logic [XLEN-1:0]   sq;
  logic [XLEN-1:0]   sr;
  logic [XLEN-1:0]   uq;
  logic [XLEN-1:0]   ur;

  // Sign-extended operands; the low 64 bits of the product are the signed result.
  assign prod_s = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{b_i[XLEN-1]}}, b_i};
  assign prod_u = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

  // Signed divide on magnitudes; |0x80000000| fits as unsigned, so the
  // 0x80000000 / -1 case naturally yields quotient 0x80000000, remainder 0.
  assign abs_a  = a_i[XLEN-1] ? (~a_i + XLEN'(1)) : a_i;
  assign abs_b  = b_i[XLEN-1] ? (~b_i + XLEN'(1)) : b_i;
  // A zero divisor is replaced by 1 so the divider never sees 0; result is discarded.
  assign sdiv_b = (abs_b == '0) ? XLEN'(1) : abs_b;
  assign udiv_b = (b_i == '0) ? XLEN'(1) : b_i;
  assign sq     = abs_a / sdiv_b;
  assign sr     = abs_a % sdiv_b;
  assign uq     = a_i / udiv_b;
  assign ur     = a_i % udiv_b;

  // Result select; quotient sign from operand signs, remainder takes dividend sign.
  always_comb begin
    res_o = '0;
    case (mdu_op_e'(op_i))
      MDU_MULT: begin
        res_o.hi = prod_s[2*XLEN-1:XLEN];
        res_o.lo = prod_s[XLEN-1:0];
      end
      MDU_MULTU: begin
        res_o.hi = prod_u[2*XLEN-1:XLEN];
        res_o.lo = prod_u[XLEN-1:0];
      end
      MDU_DIV: begin
        res_o.div0 = (b_i == '0);
        res_o.lo   = (a_i[XLEN-1] ^ b_i[XLEN-1]) ? (~sq + XLEN'(1)) : sq;
        res_o.hi   = a_i[XLEN-1] ? (~sr + XLEN'(1)) : sr;
      end
      MDU_DIVU: begin
        res_o.div0 = (b_i == '0);
        res_o.lo   = uq;
        res_o.hi   = ur;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_controller.sv
// MDU controller: sequences multi-cycle mult/div, owns HI/LO, requests D-stage stalls.
//   clk, reset           : clock (rising edge), async active-low reset
//   start, op, flush     : E-stage MDU op request; flush kills the request
//   rs_val, rt_val       : operands (rs also feeds mthi/mtlo)
//   md_use_D             : D-stage instruction touches the MDU
//   busy                 : registered, high while an op is in flight
//   stall_req            : combinational stall request to hazard logic
//   hi, lo               : HI/LO registers
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            md_use_D,
  output logic            busy,
  output logic            stall_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             accept;
  mdu_res_t         res;

  mdu_arith u_arith (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (res)
  );

  assign accept = start & ~flush & (state_q == ST_IDLE);

  // Next-state: accept in IDLE, count down in BUSY, commit result when cnt hits 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_long_op(op)) begin
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = is_div_op(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state_d = ST_BUSY;
            busy_d  = 1'b1;
          end else if (mdu_op_e'(op) == MDU_MTHI) begin
            hi_d = rs_val;
          end else if (mdu_op_e'(op) == MDU_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_BUSY: begin
        // start/flush are ignored here: an in-flight op always completes.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (!res.div0) begin
            hi_d = res.hi;
            lo_d = res.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, operand latches and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // Stall also covers the cycle a long op is being accepted, before busy rises.
  assign stall_req = md_use_D & (busy_q | (start & ~flush & is_long_op(op)));

endmodule

// File: tb/tb_mdu_controller.sv
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .flush     (flush),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_use_D  (md_use_D),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.cycles = n;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Bounded wait for busy to drop, plus one cycle so the monitor has scored it.
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Hazard logic must never present start while busy.
  always @(posedge clk) begin
    if (reset && start && busy)
      $error("start presented while busy");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    flush    = 1'b0;
    rs_val   = '0;
    rt_val   = '0;
    md_use_D = 1'b0;

    // Monitor: scores HI/LO and busy length on every falling edge of busy.
    fork
      begin : monitor
        logic prev_busy;
        int   busy_cnt;
        exp_t e;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
          @(negedge clk);
          if (!reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
          end else begin
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected result: hi %h lo %h with nothing expected", hi, lo);
              end else begin
                e = sb.pop_front();
                check("result hi", hi, e.hi);
                check("result lo", lo, e.lo);
                check("busy cycles", 32'(busy_cnt), 32'(e.cycles));
              end
              busy_cnt = 0;
            end
            prev_busy = busy;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // mult -2 * 3
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult");

    // multu with stall checks; HI/LO must hold old values while busy
    @(negedge clk);
    expect_result(32'h00000002, 32'hFFFFFFFA, 5);
    md_use_D = 1'b1;
    start    = 1'b1;
    op       = 3'd1;
    rs_val   = 32'hFFFFFFFE;
    rt_val   = 32'd3;
    #1 check("stall on accept", 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall while busy", 32'(stall_req), 32'd1);
      check("hi stable in busy", hi, 32'hFFFFFFFF);
      check("lo stable in busy", lo, 32'hFFFFFFFA);
      @(negedge clk);
    end
    md_use_D = 1'b0;
    #1 check("no stall without D use", 32'(stall_req), 32'd0);
    wait_idle("multu");

    // div -7 / 2
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle("div");

    // divu by zero keeps HI/LO
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd3, 32'd55, 32'd0);
    wait_idle("divu0");

    // div overflow case
    expect_result(32'h00000000, 32'h80000000, 10);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div ovf");

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    start  = 1'b1;
    op     = 3'd4;
    rs_val = 32'h12345678;
    @(negedge clk);
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo kept", lo, 32'h80000000);
    check("mthi busy", 32'(busy), 32'd0);
    op     = 3'd5;
    rs_val = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h9ABCDEF0);
    check("mtlo hi kept", hi, 32'h12345678);
    check("mtlo busy", 32'(busy), 32'd0);

    // start + flush in same cycle: no effect
    @(negedge clk);
    md_use_D = 1'b1;
    start    = 1'b1;
    flush    = 1'b1;
    op       = 3'd0;
    rs_val   = 32'd5;
    rt_val   = 32'd5;
    #1 check("no stall when flushed", 32'(stall_req), 32'd0);
    @(negedge clk);
    start    = 1'b0;
    flush    = 1'b0;
    md_use_D = 1'b0;
    check("flushed busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("flushed hi", hi, 32'h12345678);
    check("flushed lo", lo, 32'h9ABCDEF0);

    // reserved op 6 is a no-op
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    check("rsv busy", 32'(busy), 32'd0);
    check("rsv hi", hi, 32'h12345678);
    check("rsv lo", lo, 32'h9ABCDEF0);

    // flush during BUSY does not cancel
    expect_result(32'h00000000, 32'd42, 5);
    issue(3'd0, 32'd7, 32'd6);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    wait_idle("flush in busy");

    // async reset in cycle 3 of a div
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid-op reset busy", 32'(busy), 32'd0);
    check("mid-op reset hi", hi, 32'd0);
    check("mid-op reset lo", lo, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // fresh divu 100 / 7
    expect_result(32'd2, 32'd14, 10);
    issue(3'd3, 32'd100, 32'd7);
    wait_idle("divu");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
